// File: rtl/mem_seq_ctrl.sv
// Data-memory access sequencer: turns a decoded load/store into a req/ack
// memory transaction, stalls decode while pending, and aborts hung accesses.
//
// state  | meaning
// IDLE   | waiting for ld_req/st_req; captures address, data and direction
// ACCESS | mem_req high, waiting for mem_ack or for the wait timer to expire
// DONE   | one-cycle completion; load_en pulses for a successful read
module mem_seq_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              start,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_en,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_en_q, load_en_d;
  logic              err_q, err_d;
  logic              timeout;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    load_en_d   = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_req || st_req) begin
          mem_addr_d  = addr_in;
          mem_wdata_d = st_data;
          mem_we_d    = st_req & ~ld_req;
          wait_d      = TIMEOUT_C;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Ack is checked first so an ack on the final timer cycle still succeeds.
        if (mem_ack) begin
          if (!mem_we_q) begin
            load_data_d = mem_rdata;
            load_en_d   = 1'b1;
          end
          state_d = S_DONE;
        end else if (wait_q == 8'd1) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    err_d = err_q;
    if (timeout) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
      load_en_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      load_en_q   <= load_en_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign load_en   = load_en_q;
  assign load_data = load_data_q;
  assign err       = err_q;
  assign stall     = ~start & (((state_q == S_IDLE) & (ld_req | st_req)) |
                               (state_q == S_ACCESS));

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: load, slow store, timeout, late ack,
// back-to-back and reset-abandon scenarios with hand-computed expectations.
module tb_mem_seq_ctrl;

  logic       clk = 1'b0;
  logic       start, ld_req, st_req, mem_ack, err_clr;
  logic [7:0] addr_in, st_data, mem_rdata;
  logic       mem_req, mem_we, load_en, stall, err;
  logic [7:0] mem_addr, mem_wdata, load_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_seq_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .start     (start),
    .ld_req    (ld_req),
    .st_req    (st_req),
    .addr_in   (addr_in),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .load_en   (load_en),
    .load_data (load_data),
    .stall     (stall),
    .err       (err),
    .err_clr   (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    start = 1'b1; ld_req = 1'b0; st_req = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
    addr_in = 8'h00; st_data = 8'h00; mem_rdata = 8'h00;
    tick();
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_err", err, 0);
    ld_req = 1'b1;
    #1;
    chk("rst_stall_held", stall, 0);
    start = 1'b0; ld_req = 1'b0;
    tick();

    // Single load, ack in cycle 1
    ld_req = 1'b1; addr_in = 8'h3C;
    #1;
    chk("ld_c0_stall", stall, 1);
    chk("ld_c0_mem_req", mem_req, 0);
    tick();
    chk("ld_c1_mem_req", mem_req, 1);
    chk("ld_c1_mem_we", mem_we, 0);
    chk("ld_c1_mem_addr", mem_addr, 8'h3C);
    chk("ld_c1_stall", stall, 1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("ld_c2_load_en", load_en, 1);
    chk("ld_c2_load_data", load_data, 8'hA5);
    chk("ld_c2_mem_req", mem_req, 0);
    chk("ld_c2_stall", stall, 0);
    ld_req = 1'b0;
    tick();
    chk("ld_c3_load_en", load_en, 0);

    // Store, ack in cycle 4
    st_req = 1'b1; addr_in = 8'h10; st_data = 8'h7E;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("st_c%0d_mem_req", c), mem_req, 1);
      chk($sformatf("st_c%0d_mem_we", c), mem_we, 1);
      chk($sformatf("st_c%0d_mem_addr", c), mem_addr, 8'h10);
      chk($sformatf("st_c%0d_mem_wdata", c), mem_wdata, 8'h7E);
      chk($sformatf("st_c%0d_load_en", c), load_en, 0);
      if (c == 4) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("st_c5_mem_req", mem_req, 0);
    chk("st_c5_stall", stall, 0);
    chk("st_c5_load_en", load_en, 0);
    chk("st_c5_load_data", load_data, 8'hA5);
    st_req = 1'b0;
    tick();

    // Load with no ack: timeout after 15 ACCESS cycles
    ld_req = 1'b1; addr_in = 8'h55;
    tick();
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("to_c%0d_mem_req", c), mem_req, 1);
      chk($sformatf("to_c%0d_err", c), err, 0);
      tick();
    end
    chk("to_c16_mem_req", mem_req, 0);
    chk("to_c16_err", err, 1);
    chk("to_c16_load_en", load_en, 0);
    chk("to_c16_load_data", load_data, 8'hA5);
    chk("to_c16_stall", stall, 0);
    ld_req = 1'b0;
    tick();
    chk("to_c17_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    chk("to_err_cleared", err, 0);

    // Second timeout with err_clr held high: set wins
    ld_req = 1'b1; addr_in = 8'h56;
    tick();
    repeat (15) tick();
    chk("to2_err_set_wins", err, 1);
    chk("to2_mem_req", mem_req, 0);
    ld_req = 1'b0;
    tick();
    chk("to2_err_cleared", err, 0);
    err_clr = 1'b0;

    // Ack on ACCESS cycle 15
    ld_req = 1'b1; addr_in = 8'h20;
    tick();
    repeat (14) tick();
    chk("late_c15_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_ack = 1'b0;
    chk("late_load_en", load_en, 1);
    chk("late_load_data", load_data, 8'h3C);
    chk("late_err", err, 0);
    ld_req = 1'b0;
    tick();
    chk("late_after_err", err, 0);

    // Simultaneous requests then back-to-back load
    ld_req = 1'b1; st_req = 1'b1; addr_in = 8'h44; st_data = 8'h99;
    tick();
    chk("both_c1_mem_we", mem_we, 0);
    chk("both_c1_mem_addr", mem_addr, 8'h44);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    chk("both_c2_load_en", load_en, 1);
    chk("both_c2_load_data", load_data, 8'h5A);
    chk("both_c2_stall", stall, 0);
    st_req = 1'b0; addr_in = 8'h66;
    tick();
    chk("b2b_c3_stall", stall, 1);
    chk("b2b_c3_mem_req", mem_req, 0);
    tick();
    chk("b2b_c4_mem_req", mem_req, 1);
    chk("b2b_c4_mem_addr", mem_addr, 8'h66);
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    chk("b2b_c5_load_en", load_en, 1);
    chk("b2b_c5_load_data", load_data, 8'hC3);
    ld_req = 1'b0;
    tick();

    // Reset in ACCESS cycle 2, then stray ack
    ld_req = 1'b1; addr_in = 8'h77;
    tick();
    tick();
    chk("rma_c2_mem_req", mem_req, 1);
    start = 1'b1; ld_req = 1'b0;
    #1;
    chk("rma_start_stall", stall, 0);
    tick();
    start = 1'b0;
    chk("rma_mem_req", mem_req, 0);
    chk("rma_mem_addr", mem_addr, 0);
    chk("rma_load_data", load_data, 0);
    chk("rma_load_en", load_en, 0);
    chk("rma_stall", stall, 0);
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    tick();
    mem_ack = 1'b0;
    chk("stray_load_en", load_en, 0);
    chk("stray_mem_req", mem_req, 0);
    tick();
    chk("stray_load_data", load_data, 0);
    chk("stray_load_en2", load_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_seq_ctrl.md
# mem_seq_ctrl

Multi-cycle data-memory access sequencer between the register file and the data memory. Accepts a load or store request from decode, drives a req/ack handshake to memory, holds the program counter with a stall while the access is pending, and returns load data with a one-cycle write-enable pulse into the register file. A bounded wait timer aborts hung accesses and raises a sticky error.

## Interface

Parameters:
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: data width; matches register width.
- `TIMEOUT`, default 15: maximum ACCESS cycles without `mem_ack` before abort; legal range 1–255.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `start`  in  1  reset; synchronous, active-high.
- `ld_req`  in  1  decoded load; level, held by decode while `stall`=1.
- `st_req`  in  1  decoded store; level, held while `stall`=1.
- `addr_in`  in  ADDR_W  access address from register file.
- `st_data`  in  DATA_W  store data from register file.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr`  out  ADDR_W  captured address.
- `mem_wdata`  out  DATA_W  captured store data.
- `mem_ack`  in  1  memory completion, single-cycle pulse.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`.
- `load_en`  out  1  one-cycle register-file load strobe.
- `load_data`  out  DATA_W  registered read data.
- `stall`  out  1  combinational PC/decode hold.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation

- States: IDLE, ACCESS, DONE. 2-bit encoding.
- IDLE: if `ld_req` or `st_req`, capture `addr_in` into `mem_addr` and `st_data` into `mem_wdata`. Set `mem_we` = `st_req & ~ld_req`. Clear the wait counter. Go to ACCESS.
- Both requests high: the access is a load, and the store is dropped. This is not an error.
- ACCESS: `mem_req`=1, and addr, wdata and we are held stable.
  - On `mem_ack`: latch `mem_rdata` into `load_data` if it is a read. Go to DONE.
  - Otherwise increment the 8-bit wait counter. When the counter equals `TIMEOUT` and there is no ack, set `err` and go to DONE with the abort flag set.
- DONE: `load_en`=1 for exactly one cycle if the access was a read and was not aborted. `mem_req`=0. Next state is IDLE unconditionally.
- Ack priority: `mem_ack` in the same cycle the counter reaches `TIMEOUT` counts as success. `err` is not set.
- `mem_ack` in IDLE or DONE is ignored, with no state or data change.
- `stall` = (IDLE & (`ld_req` | `st_req`)) | ACCESS. It is 0 in DONE, so decode advances on the DONE edge and a new request is seen in the following IDLE cycle.
- `err`: set on timeout and cleared by `err_clr`. Set wins if both occur in the same cycle.
- On an abort, `load_data` keeps its previous value.
- Reset values: state IDLE; `mem_req`, `mem_we`, `load_en`, `err`, `mem_addr`, `mem_wdata`, `load_data` and the wait counter all 0.
- `stall` = 0 while `start`=1.
- `start` mid-ACCESS: return to IDLE at that edge and drop `mem_req` in the same cycle. A later ack for the abandoned access is ignored.

## Timing

- Cycle 0: request seen in IDLE; `stall`=1.
- Cycle 1: `mem_req`=1.
- Ack in cycle k ≥ 1 gives DONE in cycle k+1: `stall`=0, and `load_en`=1 for a load.
- Back-to-back minimum: 3 cycles per access. Stall is 2 cycles with a 1-cycle memory.
- Timeout: with no ack, cycles 1..`TIMEOUT` are ACCESS; DONE is cycle `TIMEOUT`+1.
- `load_data` is valid from DONE until the next successful read.
- `mem_*` outputs change only on clock edges, never combinationally from inputs.

## Test plan

- **Single load:** `ld_req`=1 with `addr_in`=0x3C; memory acks in cycle 1 with 0xA5. Expect `mem_req` in cycle 1 only with `mem_we`=0 and `mem_addr`=0x3C, then `load_en`=1 and `load_data`=0xA5 in cycle 2, and `stall`=1 in cycles 0–1.
- **Store with slow memory:** `st_req`=1, `addr_in`=0x10, `st_data`=0x7E; ack in cycle 4. Expect `mem_we`=1 with addr and data stable in cycles 1–4, DONE in cycle 5, and `load_en` never asserted.
- **Timeout:** `TIMEOUT`=15, load with no ack. Expect `mem_req` in cycles 1–15, `err`=1 from cycle 16, no `load_en`, and `load_data` unchanged. Then `err_clr` clears `err`; `err_clr` together with a new timeout leaves `err` at 1.
- **Ack on last cycle:** ack arrives exactly in ACCESS cycle 15. Expect success: `load_en`=1 and `err`=0.
- **Simultaneous requests and back-to-back:** `ld_req`=`st_req`=1 gives a read. A second load held immediately after DONE is accepted in the next IDLE cycle, giving a 3-cycle period.
- **Reset mid-access:** `start` pulsed in ACCESS cycle 2. Expect `mem_req`=0 and IDLE on the next cycle, all outputs zero, and a stray `mem_ack` afterwards producing no `load_en`.
